// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and helpers for the pipelined core's hazard/forwarding unit.
//   tag_entry_t   : destination tag of one instruction in a post-E stage
//   PC_REG        : architectural PC register, which is never forwarded
//   fwd_sel_width : width of one forward-select field for n tracked stages
package hazard_pkg;

    // Width of the register address held in a tag. Keep it equal to the
    // unit's REG_AW.
    localparam int TAG_AW = 4;

    localparam logic [3:0] PC_REG = 4'd15;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic              pcsrc;
        logic [TAG_AW-1:0] wa;
    } tag_entry_t;

    // Select values 0..n: 0 means regfile, k means forward from stage k.
    function automatic int fwd_sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Datapath <-> hazard unit signal bundle.
//   master : datapath side. It drives the E/D instruction info and receives
//            the selects, stalls and flushes.
//   slave  : hazard unit side.
//   ra_e/ra_d pack operand i at [i*REG_AW +: REG_AW], and fwd_sel packs
//   operand i at [i*SW +: SW].
interface pipeline_hazard_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int N_SRC  = 2,
    parameter int N_FWD  = 2,
    parameter int CNT_W  = 16
);
    localparam int SW = fwd_sel_width(N_FWD);

    logic                      valid_e;
    logic                      regwrite_e;
    logic                      memtoreg_e;
    logic                      pcsrc_e;
    logic [REG_AW-1:0]         wa_e;
    logic [N_SRC*REG_AW-1:0]   ra_e;
    logic [N_SRC*REG_AW-1:0]   ra_d;
    logic [N_SRC-1:0]          src_used_d;
    logic                      pcsrc_d;
    logic                      branch_taken_e;
    logic [N_SRC*SW-1:0]       fwd_sel;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic                      pcsrc_w;
    logic [CNT_W-1:0]          ldstall_cnt;

    modport master (
        output valid_e, regwrite_e, memtoreg_e, pcsrc_e, wa_e, ra_e, ra_d,
               src_used_d, pcsrc_d, branch_taken_e,
        input  fwd_sel, stall_f, stall_d, flush_d, flush_e, pcsrc_w, ldstall_cnt
    );

    modport slave (
        input  valid_e, regwrite_e, memtoreg_e, pcsrc_e, wa_e, ra_e, ra_d,
               src_used_d, pcsrc_d, branch_taken_e,
        output fwd_sel, stall_f, stall_d, flush_d, flush_e, pcsrc_w, ldstall_cnt
    );

endinterface

// File: rtl/pipeline_hazard_unit_tag_pipe.sv
// N-deep shift register of destination tags for the post-E stages
// (entry 1 = M ... entry N = W). It shifts every clock because M/W never
// stall.
//   clk, reset : clock, async active-low clear (all entries invalid)
//   ent_i      : tag of the instruction leaving E
//   pipe_o     : current entries, index 1 youngest
module hazard_tag_pipe
    import hazard_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  tag_entry_t            ent_i,
    output tag_entry_t [N:1]      pipe_o
);
    tag_entry_t [N:1] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[1] = ent_i;
        for (int k = 2; k <= N; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pipe_q <= '0;
        else        pipe_q <= pipe_d;
    end

    assign pipe_o = pipe_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/forwarding controller for the pipelined ARM core.
//   clk, reset : core clock, async active-low reset (all outputs forced 0 while low)
//   hz         : slave side of pipeline_hazard_unit_if
//                inputs : E/D instruction info, branch resolution
//                outputs: per-operand forward selects, stall/flush controls,
//                         pcsrc_w, saturating load-use stall counter
// All outputs except ldstall_cnt are combinational (zero-cycle latency).
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 4,
    parameter int N_SRC      = 2,
    parameter int N_FWD      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_unit_if.slave  hz
);
    localparam int SW = fwd_sel_width(N_FWD);
    localparam logic [REG_AW-1:0] PC_A = REG_AW'(PC_REG);

    tag_entry_t           ent_in;
    tag_entry_t [N_FWD:1] pipe;

    // Control bits are qualified by valid so a flushed E slot never creates a
    // candidate downstream.
    always_comb begin
        ent_in          = '0;
        ent_in.valid    = hz.valid_e;
        ent_in.regwrite = hz.regwrite_e & hz.valid_e;
        ent_in.memtoreg = hz.memtoreg_e & hz.valid_e;
        ent_in.pcsrc    = hz.pcsrc_e & hz.valid_e;
        ent_in.wa       = TAG_AW'(hz.wa_e);
    end

    hazard_tag_pipe #(.N(N_FWD)) u_tag_pipe (
        .clk    (clk),
        .reset  (reset),
        .ent_i  (ent_in),
        .pipe_o (pipe)
    );

    logic [N_SRC-1:0][SW-1:0] fwd_c;
    logic [N_SRC-1:0]         lu_vec;
    logic [N_SRC-1:0]         early_vec;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        logic [REG_AW-1:0] ra_e, ra_d;
        logic [SW-1:0]     sel;
        logic              lu, early;

        assign ra_e = hz.ra_e[i*REG_AW +: REG_AW];
        assign ra_d = hz.ra_d[i*REG_AW +: REG_AW];

        // Walk from oldest to youngest so the youngest match wins.
        // Load results only become candidates once the data exists
        // (k >= LOAD_STAGE).
        always_comb begin
            sel   = '0;
            early = 1'b0;
            for (int k = N_FWD; k >= 1; k--) begin
                if (pipe[k].valid && pipe[k].regwrite && ra_e != PC_A &&
                    pipe[k].wa[REG_AW-1:0] == ra_e) begin
                    if (!pipe[k].memtoreg || k >= LOAD_STAGE) sel = SW'(k);
                    else                                      early = hz.valid_e;
                end
            end
        end

        // A load at position p (0 = E) is still too young to forward when its
        // dependant reaches E one cycle later, i.e. when p+1 < LOAD_STAGE.
        always_comb begin
            lu = 1'b0;
            if (hz.src_used_d[i] && ra_d != PC_A) begin
                if (1 < LOAD_STAGE && hz.valid_e && hz.regwrite_e &&
                    hz.memtoreg_e && hz.wa_e == ra_d) lu = 1'b1;
                for (int k = 1; k <= N_FWD; k++) begin
                    if (k + 1 < LOAD_STAGE && pipe[k].valid && pipe[k].regwrite &&
                        pipe[k].memtoreg && pipe[k].wa[REG_AW-1:0] == ra_d) lu = 1'b1;
                end
            end
        end

        assign fwd_c[i]     = sel;
        assign lu_vec[i]    = lu;
        assign early_vec[i] = early;
    end

    logic ldstall, pc_pend, pcsrc_w_c;

    assign ldstall = |lu_vec;

    always_comb begin
        pc_pend = hz.pcsrc_d | (hz.pcsrc_e & hz.valid_e);
        for (int k = 1; k < N_FWD; k++) pc_pend = pc_pend | pipe[k].pcsrc;
    end

    assign pcsrc_w_c = pipe[N_FWD].pcsrc;

    // Reset gates every combinational output so a stall drops immediately.
    assign hz.fwd_sel = reset ? fwd_c : '0;
    assign hz.stall_f = reset & (ldstall | pc_pend);
    assign hz.stall_d = reset & ldstall;
    assign hz.flush_d = reset & (pc_pend | pcsrc_w_c | hz.branch_taken_e);
    assign hz.flush_e = reset & (ldstall | hz.branch_taken_e);
    assign hz.pcsrc_w = reset & pcsrc_w_c;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ldstall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign hz.ldstall_cnt = cnt_q;

    // The stall logic must keep any live E operand off a load that cannot
    // forward yet.
    a_no_early_load: assert property (@(posedge clk) disable iff (!reset) early_vec == '0);

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;
    import hazard_pkg::*;

    localparam int REG_AW = 4, N_SRC = 2, N_FWD = 2, LOAD_STAGE = 2, CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.REG_AW(REG_AW), .N_SRC(N_SRC), .N_FWD(N_FWD), .CNT_W(CNT_W)) hif();

    pipeline_hazard_unit #(
        .REG_AW(REG_AW), .N_SRC(N_SRC), .N_FWD(N_FWD),
        .LOAD_STAGE(LOAD_STAGE), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    typedef struct {
        logic       valid, rw, mtr, pcs;
        logic [3:0] wa, rae0, rae1, rad0, rad1;
        logic [1:0] used;
        logic       pcsd, br;
    } in_t;

    typedef struct {
        int f0, f1, sf, sd, fd, fe, pw, cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic in_t mk(input logic v, rw, mtr, pcs, input logic [3:0] wa,
                               rae0, rae1, rad0, rad1, input logic [1:0] used,
                               input logic pcsd, br);
        in_t s;
        s.valid = v; s.rw = rw; s.mtr = mtr; s.pcs = pcs; s.wa = wa;
        s.rae0 = rae0; s.rae1 = rae1; s.rad0 = rad0; s.rad1 = rad1;
        s.used = used; s.pcsd = pcsd; s.br = br;
        return s;
    endfunction

    function automatic exp_t ex(input int f0, f1, sf, sd, fd, fe, pw, cnt);
        exp_t e;
        e.f0 = f0; e.f1 = f1; e.sf = sf; e.sd = sd;
        e.fd = fd; e.fe = fe; e.pw = pw; e.cnt = cnt;
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        if (obs != expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs, queue the expectation, compare on the
    // falling edge, then advance past the next rising edge.
    task automatic step(input string tag, input in_t s, input exp_t e);
        exp_t x;
        hif.valid_e        = s.valid;
        hif.regwrite_e     = s.rw;
        hif.memtoreg_e     = s.mtr;
        hif.pcsrc_e        = s.pcs;
        hif.wa_e           = s.wa;
        hif.ra_e           = {s.rae1, s.rae0};
        hif.ra_d           = {s.rad1, s.rad0};
        hif.src_used_d     = s.used;
        hif.pcsrc_d        = s.pcsd;
        hif.branch_taken_e = s.br;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        chk({tag, ".fwd0"},   int'(hif.fwd_sel[1:0]),   x.f0);
        chk({tag, ".fwd1"},   int'(hif.fwd_sel[3:2]),   x.f1);
        chk({tag, ".stallf"}, int'(hif.stall_f),        x.sf);
        chk({tag, ".stalld"}, int'(hif.stall_d),        x.sd);
        chk({tag, ".flushd"}, int'(hif.flush_d),        x.fd);
        chk({tag, ".flushe"}, int'(hif.flush_e),        x.fe);
        chk({tag, ".pcsrcw"}, int'(hif.pcsrc_w),        x.pw);
        chk({tag, ".cnt"},    int'(hif.ldstall_cnt),    x.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // reset: busy inputs, everything must read 0
        step("rst",      mk(1,1,0,0,3, 3,3, 0,0,2'b00, 1,1), ex(0,0,0,0,0,0,0,0));
        reset = 1'b1;

        // ALU->ALU forwarding from M then W
        step("alu_e",    mk(1,1,0,0,3, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,0));
        step("alu_m",    mk(0,0,0,0,0, 3,0, 0,0,2'b00, 0,0), ex(1,0,0,0,0,0,0,0));
        step("alu_w",    mk(0,0,0,0,0, 3,0, 0,0,2'b00, 0,0), ex(2,0,0,0,0,0,0,0));

        // priority: youngest writer wins; R15 never forwarded
        step("pri_a",    mk(1,1,0,0,3, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,0));
        step("pri_b",    mk(1,1,0,0,3, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,0));
        step("pri_c",    mk(1,1,0,0,15,15,3, 0,0,2'b00, 0,0), ex(0,1,0,0,0,0,0,0));
        step("pri_r15",  mk(0,0,0,0,0, 15,3, 0,0,2'b00, 0,0), ex(0,2,0,0,0,0,0,0));

        // load-use: one stall cycle, then forward from W
        step("ld_e",     mk(1,1,1,0,5, 0,0, 0,5,2'b10, 0,0), ex(0,0,1,1,0,1,0,0));
        step("ld_bub",   mk(0,0,0,0,0, 0,0, 0,5,2'b10, 0,0), ex(0,0,0,0,0,0,0,1));
        step("ld_fwd",   mk(1,0,0,0,0, 0,5, 0,0,2'b00, 0,0), ex(0,2,0,0,0,0,0,1));
        step("ld_unused",mk(1,1,1,0,5, 0,0, 0,5,2'b01, 0,0), ex(0,0,0,0,0,0,0,1));
        step("ld_idle",  mk(0,0,0,0,0, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,1));
        step("ld_r15",   mk(1,1,1,0,15, 0,0, 15,15,2'b11, 0,0), ex(0,0,0,0,0,0,0,1));

        // PC write travelling D -> E -> M -> W
        step("pc_d",     mk(0,0,0,0,0, 0,0, 0,0,2'b00, 1,0), ex(0,0,1,0,1,0,0,1));
        step("pc_e",     mk(1,1,0,1,15, 0,0, 0,0,2'b00, 0,0), ex(0,0,1,0,1,0,0,1));
        step("pc_m",     mk(0,0,0,0,0, 0,0, 0,0,2'b00, 0,0), ex(0,0,1,0,1,0,0,1));
        step("pc_w",     mk(0,0,0,0,0, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,1,0,1,1));
        step("br",       mk(0,0,0,0,0, 0,0, 0,0,2'b00, 0,1), ex(0,0,0,0,1,1,0,1));
        step("ld_br",    mk(1,1,1,0,6, 0,0, 6,0,2'b01, 0,1), ex(0,0,1,1,1,1,0,1));
        step("post",     mk(0,0,0,0,0, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,2));

        // counter saturates at 15
        for (int j = 0; j < 20; j++)
            step("sat", mk(1,1,1,0,7, 0,0, 7,7,2'b11, 0,0),
                 ex(0,0,1,1,0,1,0, (2 + j > 15) ? 15 : 2 + j));
        step("sat_hold", mk(0,0,0,0,0, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,15));

        // reset mid-operation with a stall active and writers in flight
        step("rst_pre",  mk(1,1,1,0,8, 0,0, 8,0,2'b01, 0,0), ex(0,0,1,1,0,1,0,15));
        step("rst_alu",  mk(1,1,0,0,9, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,15));
        reset = 1'b0;
        step("rst_mid",  mk(1,1,1,0,8, 9,8, 8,8,2'b11, 1,1), ex(0,0,0,0,0,0,0,0));
        reset = 1'b1;
        step("rst_after",mk(0,0,0,0,0, 9,8, 8,8,2'b11, 0,0), ex(0,0,0,0,0,0,0,0));
        step("rst_new",  mk(1,1,0,0,4, 0,0, 0,0,2'b00, 0,0), ex(0,0,0,0,0,0,0,0));
        step("rst_fwd",  mk(0,0,0,0,0, 4,0, 0,0,2'b00, 0,0), ex(1,0,0,0,0,0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
